// File: rtl/id_operand_sb.sv
// Decode operand fetch: NFWD-priority bypass plus per-GPR pending-write scoreboard (RAW, WAW, load-use).
// Latency: operands and stall request are combinational; scoreboard counters update on clk.
// Backpressure: stallreq_o holds ID, stall_i/flush_i only gate issue. `define ID_SB_PERF_EN adds stall/WAW counters.
module id_operand_sb #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int NFWD    = 2,
  parameter int MAX_LAT = 15,
  localparam int CW     = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic             rs_read_i,
  input  logic             rt_read_i,
  input  logic [AW-1:0]    rs_addr_i,
  input  logic [AW-1:0]    rt_addr_i,
  input  logic [DW-1:0]    rs_rdata_i,
  input  logic [DW-1:0]    rt_rdata_i,
  input  logic [DW-1:0]    imm_i,
  input  logic             wreg_i,
  input  logic [AW-1:0]    wd_i,
  input  logic [CW-1:0]    lat_i,
  input  logic [NFWD-1:0]  fwd_wreg_i,
  input  logic [NFWD-1:0]  fwd_ready_i,
  input  logic [NFWD*AW-1:0] fwd_wd_i,
  input  logic [NFWD*DW-1:0] fwd_wdata_i,
  output logic [DW-1:0]    op1_o,
  output logic [DW-1:0]    op2_o,
  output logic             stallreq_o,
`ifdef ID_SB_PERF_EN
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      waw_cnt_o,
`endif
  output logic             issue_o
);

  localparam logic [CW:0] LAT_MAX = (CW+1)'(MAX_LAT);

  // Cycles until the pending write to each GPR lands; entry 0 is never loaded.
  logic [CW-1:0] cnt [NREG];

  logic [DW:0]   rs_res, rt_res;
  logic          rs_haz, rt_haz, waw_haz;
  logic [CW-1:0] lat_sat;

  // Returns {hazard, operand}; descending scan lets the youngest matching channel win.
  function automatic logic [DW:0] resolve(input logic rd, input logic [AW-1:0] a,
                                          input logic [DW-1:0] rf, input logic pend);
    logic [DW:0] r;
    r = {1'b0, imm_i};
    if (rd) begin
      if (a == '0) begin
        r = '0;
      end else begin
        r = {pend, rf};
        for (int k = NFWD - 1; k >= 0; k--) begin
          if (fwd_wreg_i[k] && (fwd_wd_i[k*AW +: AW] == a))
            r = {~fwd_ready_i[k], fwd_wdata_i[k*DW +: DW]};
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    rs_res = resolve(rs_read_i, rs_addr_i, rs_rdata_i, cnt[rs_addr_i] != '0);
    rt_res = resolve(rt_read_i, rt_addr_i, rt_rdata_i, cnt[rt_addr_i] != '0);
  end

  assign rs_haz  = rs_res[DW];
  assign rt_haz  = rt_res[DW];
  assign waw_haz = id_valid_i & wreg_i & (wd_i != '0) & (cnt[wd_i] != '0);

  assign op1_o      = rst ? '0 : rs_res[DW-1:0];
  assign op2_o      = rst ? '0 : rt_res[DW-1:0];
  assign stallreq_o = ~rst & id_valid_i & (rs_haz | rt_haz | waw_haz);
  assign issue_o    = ~rst & id_valid_i & ~stallreq_o & ~stall_i & ~flush_i;

  assign lat_sat = ({1'b0, lat_i} > LAT_MAX) ? LAT_MAX[CW-1:0] : lat_i;

  // Producers drain independently of ID, so counters keep decrementing through stall_i.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
      end
      if (issue_o && wreg_i && (wd_i != '0) && (lat_i != '0))
        cnt[wd_i] <= lat_sat;
    end
  end

`ifdef ID_SB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
      waw_cnt_o   <= '0;
    end else begin
      if (stallreq_o) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (waw_haz && !rs_haz && !rt_haz) waw_cnt_o <= waw_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_operand_sb.sv
// Scoreboard bench for id_operand_sb: driver pushes model predictions, monitor pops and compares each cycle.
module tb_id_operand_sb;
  localparam int NFWD = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MAX_LAT = 15;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall_i, flush_i, id_valid_i, rs_read_i, rt_read_i, wreg_i;
  logic [AW-1:0] rs_addr_i, rt_addr_i, wd_i;
  logic [DW-1:0] rs_rdata_i, rt_rdata_i, imm_i;
  logic [CW-1:0] lat_i;
  logic [NFWD-1:0] fwd_wreg_i, fwd_ready_i;
  logic [NFWD*AW-1:0] fwd_wd_i;
  logic [NFWD*DW-1:0] fwd_wdata_i;
  logic [DW-1:0] op1_o, op2_o;
  logic stallreq_o, issue_o;
`ifdef ID_SB_PERF_EN
  logic [31:0] stall_cnt_o, waw_cnt_o;
`endif

  id_operand_sb dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .rs_read_i(rs_read_i), .rt_read_i(rt_read_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rs_rdata_i(rs_rdata_i), .rt_rdata_i(rt_rdata_i), .imm_i(imm_i), .wreg_i(wreg_i), .wd_i(wd_i),
    .lat_i(lat_i), .fwd_wreg_i(fwd_wreg_i), .fwd_ready_i(fwd_ready_i), .fwd_wd_i(fwd_wd_i),
    .fwd_wdata_i(fwd_wdata_i), .op1_o(op1_o), .op2_o(op2_o), .stallreq_o(stallreq_o),
`ifdef ID_SB_PERF_EN
    .stall_cnt_o(stall_cnt_o), .waw_cnt_o(waw_cnt_o),
`endif
    .issue_o(issue_o)
  );

  typedef struct packed {
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic          stall;
    logic          issue;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  // Reference: absolute cycle from which each register has no pending write.
  int busy_until[32];

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, want);
    end
  endtask

  task automatic resolve(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] rf,
                         output logic [DW-1:0] op, output logic h);
    int hit;
    hit = -1;
    op = imm_i;
    h = 1'b0;
    if (rd) begin
      if (a == 0) op = '0;
      else begin
        for (int k = 0; k < NFWD; k++)
          if (hit < 0 && fwd_wreg_i[k] && fwd_wd_i[k*AW +: AW] == a) hit = k;
        if (hit >= 0) begin
          op = fwd_wdata_i[hit*DW +: DW];
          h = !fwd_ready_i[hit];
        end else begin
          op = rf;
          h = (cyc < busy_until[a]);
        end
      end
    end
  endtask

  // Predict this cycle's outputs, advance the reference, then move to the next cycle.
  task automatic step();
    exp_t e;
    logic h1, h2, waw;
    int l;
    e = '0;
    if (!rst) begin
      resolve(rs_read_i, rs_addr_i, rs_rdata_i, e.op1, h1);
      resolve(rt_read_i, rt_addr_i, rt_rdata_i, e.op2, h2);
      waw = id_valid_i && wreg_i && wd_i != 0 && (cyc < busy_until[wd_i]);
      e.stall = id_valid_i && (h1 || h2 || waw);
      e.issue = id_valid_i && !e.stall && !stall_i && !flush_i;
    end
    exp_q.push_back(e);
    if (rst || flush_i) begin
      for (int r = 0; r < 32; r++) if (busy_until[r] > cyc + 1) busy_until[r] = cyc + 1;
    end else if (e.issue && wreg_i && wd_i != 0 && lat_i != 0) begin
      l = int'(lat_i);
      if (l > MAX_LAT) l = MAX_LAT;
      busy_until[wd_i] = cyc + 1 + l;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    rst = 0; stall_i = 0; flush_i = 0; id_valid_i = 0; rs_read_i = 0; rt_read_i = 0;
    rs_addr_i = 0; rt_addr_i = 0; wreg_i = 0; wd_i = 0; lat_i = 0;
    rs_rdata_i = $urandom; rt_rdata_i = $urandom; imm_i = $urandom;
    fwd_wreg_i = 0; fwd_ready_i = '1; fwd_wd_i = 0; fwd_wdata_i = 0;
  endtask

  task automatic issue_write(input logic [AW-1:0] wd, input logic [CW-1:0] lat);
    idle();
    id_valid_i = 1; wreg_i = 1; wd_i = wd; lat_i = lat;
    step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("op1", op1_o, e.op1);
        chk("op2", op2_o, e.op2);
        chk("stallreq", {31'd0, stallreq_o}, {31'd0, e.stall});
        chk("issue", {31'd0, issue_o}, {31'd0, e.issue});
      end
    end
  end

  initial begin : driver
    int n;
    logic done;
    for (int r = 0; r < 32; r++) busy_until[r] = 0;
    idle();
    rst = 1;
    @(negedge clk);
    // Reset with a live instruction presented: outputs forced to zero.
    id_valid_i = 1; rs_read_i = 1; rs_addr_i = 5; rs_rdata_i = 32'h1234;
    step(); step();

    // Forward priority: youngest channel wins.
    idle();
    id_valid_i = 1; rs_read_i = 1; rs_addr_i = 5;
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd5, 5'd5}; fwd_wdata_i = {32'h22, 32'h11};
    step();

    // Load-use stall, then data arrives.
    idle();
    id_valid_i = 1; rt_read_i = 1; rt_addr_i = 7;
    fwd_wreg_i = 2'b01; fwd_ready_i = 2'b00; fwd_wd_i = {5'd0, 5'd7}; fwd_wdata_i = {32'h0, 32'hDEAD};
    step();
    fwd_ready_i = 2'b01; fwd_wdata_i = {32'h0, 32'hABCD};
    step();

    // Multi-cycle RAW with lat=4, dependent held in ID.
    issue_write(5'd3, 4'd4);
    idle();
    id_valid_i = 1; rs_read_i = 1; rs_addr_i = 3; rs_rdata_i = 32'hC0FFEE;
    for (int i = 0; i < 6; i++) step();

    // WAW at maximum latency: count stall cycles of a following write.
    issue_write(5'd9, 4'd15);
    idle();
    id_valid_i = 1; wreg_i = 1; wd_i = 9;
    n = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (stallreq_o) n++;
      if (issue_o) done = 1;
      step();
    end
    chk("waw_stall_cycles", n, 15);
    chk("waw_eventual_issue", {31'd0, done}, 32'd1);

    // Flush clears a pending write.
    issue_write(5'd3, 4'd5);
    idle(); flush_i = 1; step();
    idle(); id_valid_i = 1; rs_read_i = 1; rs_addr_i = 3; step();

    // r0 reads as zero even with a bypass to r0; writes to r0 set no counter.
    idle();
    id_valid_i = 1; rs_read_i = 1; rs_addr_i = 0;
    fwd_wreg_i = 2'b01; fwd_wd_i = 0; fwd_wdata_i = {32'h0, 32'hFFFF};
    wreg_i = 1; wd_i = 0; lat_i = 5;
    step();
    idle(); id_valid_i = 1; wreg_i = 1; wd_i = 0; step();

    // Reset clears a nonzero counter.
    issue_write(5'd4, 4'd10);
    idle(); rst = 1; id_valid_i = 1; rs_read_i = 1; rs_addr_i = 4; step();
    idle(); id_valid_i = 1; rs_read_i = 1; rs_addr_i = 4; step();

    // Randomized traffic on a narrow register window to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      idle();
      rst        = ($urandom_range(0, 99) == 0);
      flush_i    = ($urandom_range(0, 29) == 0);
      stall_i    = ($urandom_range(0, 9) == 0);
      id_valid_i = ($urandom_range(0, 4) != 0);
      rs_read_i  = ($urandom_range(0, 3) != 0);
      rt_read_i  = ($urandom_range(0, 3) != 0);
      rs_addr_i  = 5'($urandom_range(0, 7));
      rt_addr_i  = 5'($urandom_range(0, 7));
      wreg_i     = $urandom_range(0, 1);
      wd_i       = 5'($urandom_range(0, 7));
      lat_i      = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      for (int k = 0; k < NFWD; k++) begin
        fwd_wreg_i[k]             = $urandom_range(0, 1);
        fwd_ready_i[k]            = ($urandom_range(0, 3) != 0);
        fwd_wd_i[k*AW +: AW]      = 5'($urandom_range(0, 7));
        fwd_wdata_i[k*DW +: DW]   = $urandom;
      end
      step();
    end

    idle();
    @(negedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
